// File: rtl/address_register_file_param.sv
// Parameterised address register file: NUM_REGS registers with shared-bus write ops, sticky wrap flags and two combinational read ports.
// Optional build macro ADDRESS_REGISTER_FILE_SATURATE_EN clamps inc/dec/add/sub results instead of wrapping.
module address_register_file_param #(
    parameter int              WIDTH     = 32'sd16,
    parameter int              NUM_REGS  = 32'sd4,
    parameter int              SEL_W     = 32'sd2,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [WIDTH-1:0]    I,
    input  logic [NUM_REGS-1:0] RegSel,
    input  logic [2:0]          FunSel,
    input  logic                FlagClr,
    input  logic [SEL_W-1:0]    OutCSel,
    input  logic [SEL_W-1:0]    OutDSel,
    output logic [WIDTH-1:0]    OutC,
    output logic [WIDTH-1:0]    OutD,
    output logic [NUM_REGS-1:0] WrapFlags
);

    localparam logic [2:0] OP_DEC  = 3'b000;
    localparam logic [2:0] OP_INC  = 3'b001;
    localparam logic [2:0] OP_LOAD = 3'b010;
    localparam logic [2:0] OP_CLR  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_LOWL = 3'b110;

    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]    regFile_r   [NUM_REGS];
    logic [WIDTH-1:0]    nextReg_s   [NUM_REGS];
    logic [WIDTH:0]      opRes_s     [NUM_REGS];
    logic [NUM_REGS-1:0] wrapFlags_r;
    logic [NUM_REGS-1:0] nextFlags_s;
    logic [NUM_REGS-1:0] setFlag_s;
    logic [NUM_REGS-1:0] clrFlag_s;
    logic [WIDTH-1:0]    outC_s;
    logic [WIDTH-1:0]    outD_s;

    // Result of one op on one register: {wrapFlagSet, newValue}.
    function automatic logic [WIDTH:0] applyOp(
        input logic [WIDTH-1:0] oldVal,
        input logic [2:0]       fun,
        input logic [WIDTH-1:0] din
    );
        logic [WIDTH:0]   sumExt;
        logic [WIDTH:0]   diffExt;
        logic [WIDTH-1:0] res;
        logic             flag;
        sumExt  = {1'b0, oldVal} + {1'b0, din};
        diffExt = {1'b0, oldVal} - {1'b0, din};
        res     = oldVal;
        flag    = 1'b0;
        case (fun)
            OP_DEC: begin
                flag = (oldVal == ALL_ZERO);
`ifdef ADDRESS_REGISTER_FILE_SATURATE_EN
                res  = flag ? ALL_ZERO : (oldVal - ONE_VAL);
`else
                res  = oldVal - ONE_VAL;
`endif
            end
            OP_INC: begin
                flag = (oldVal == ALL_ONES);
`ifdef ADDRESS_REGISTER_FILE_SATURATE_EN
                res  = flag ? ALL_ONES : (oldVal + ONE_VAL);
`else
                res  = oldVal + ONE_VAL;
`endif
            end
            OP_LOAD: res = din;
            OP_CLR:  res = ALL_ZERO;
            OP_ADD: begin
                flag = sumExt[WIDTH];
`ifdef ADDRESS_REGISTER_FILE_SATURATE_EN
                res  = flag ? ALL_ONES : sumExt[WIDTH-1:0];
`else
                res  = sumExt[WIDTH-1:0];
`endif
            end
            OP_SUB: begin
                // Borrow out of the extended subtraction means I > R.
                flag = diffExt[WIDTH];
`ifdef ADDRESS_REGISTER_FILE_SATURATE_EN
                res  = flag ? ALL_ZERO : diffExt[WIDTH-1:0];
`else
                res  = diffExt[WIDTH-1:0];
`endif
            end
            OP_LOWL: res = {oldVal[WIDTH-1:WIDTH/2], din[WIDTH/2-1:0]};
            default: res = oldVal;
        endcase
        return {flag, res};
    endfunction

    // Next register values and flags; a flag set beats any clear in the same cycle.
    always_comb begin
        nextReg_s   = regFile_r;
        nextFlags_s = wrapFlags_r;
        setFlag_s   = {NUM_REGS{1'b0}};
        clrFlag_s   = {NUM_REGS{1'b0}};
        opRes_s     = '{default: {(WIDTH+1){1'b0}}};
        for (int k = 0; k < NUM_REGS; k++) begin
            opRes_s[k] = applyOp(regFile_r[k], FunSel, I);
            if (!RegSel[k]) begin
                nextReg_s[k] = opRes_s[k][WIDTH-1:0];
                setFlag_s[k] = opRes_s[k][WIDTH];
                clrFlag_s[k] = (FunSel == OP_CLR);
            end else begin
                nextReg_s[k] = regFile_r[k];
                setFlag_s[k] = 1'b0;
                clrFlag_s[k] = 1'b0;
            end
            if (setFlag_s[k]) begin
                nextFlags_s[k] = 1'b1;
            end else if (clrFlag_s[k] || FlagClr) begin
                nextFlags_s[k] = 1'b0;
            end else begin
                nextFlags_s[k] = wrapFlags_r[k];
            end
        end
    end

    // Register and flag state with asynchronous reset.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regFile_r[k] <= RESET_VAL;
            end
            wrapFlags_r <= {NUM_REGS{1'b0}};
        end else begin
            regFile_r   <= nextReg_s;
            wrapFlags_r <= nextFlags_s;
        end
    end

    // Zero-latency read ports; out-of-range indices read as zero.
    always_comb begin
        outC_s = ALL_ZERO;
        outD_s = ALL_ZERO;
        if (int'(OutCSel) < NUM_REGS) begin
            outC_s = regFile_r[OutCSel];
        end else begin
            outC_s = ALL_ZERO;
        end
        if (int'(OutDSel) < NUM_REGS) begin
            outD_s = regFile_r[OutDSel];
        end else begin
            outD_s = ALL_ZERO;
        end
    end

    assign OutC      = outC_s;
    assign OutD      = outD_s;
    assign WrapFlags = wrapFlags_r;

endmodule

// File: tb/tb_address_register_file_param.sv
// Scoreboard bench for address_register_file_param: a behavioural model pushes expected read-port and flag values, popped after each edge.
module tb_address_register_file_param;

`ifdef ADDRESS_REGISTER_FILE_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] I;
    logic [3:0]  RegSel;
    logic [2:0]  FunSel;
    logic        FlagClr;
    logic [1:0]  OutCSel, OutDSel;
    logic [15:0] OutC, OutD;
    logic [3:0]  WrapFlags;

    logic [2:0]  RegSel3;
    logic [1:0]  OutCSel3, OutDSel3;
    logic [15:0] OutC3, OutD3;
    logic [2:0]  WrapFlags3;

    logic [15:0] mReg [4];
    logic [3:0]  mFlag;
    logic [31:0] expQ[$];
    string       tagQ[$];
    int          vecCount = 0;
    int          missCount = 0;

    address_register_file_param dut (
        .Clock(Clock), .Reset(Reset), .I(I), .RegSel(RegSel), .FunSel(FunSel),
        .FlagClr(FlagClr), .OutCSel(OutCSel), .OutDSel(OutDSel),
        .OutC(OutC), .OutD(OutD), .WrapFlags(WrapFlags)
    );

    address_register_file_param #(.NUM_REGS(3), .RESET_VAL(16'h00A5)) dut3 (
        .Clock(Clock), .Reset(Reset), .I(I), .RegSel(RegSel3), .FunSel(FunSel),
        .FlagClr(1'b0), .OutCSel(OutCSel3), .OutDSel(OutDSel3),
        .OutC(OutC3), .OutD(OutD3), .WrapFlags(WrapFlags3)
    );

    always #5 Clock = ~Clock;

    task automatic checkResult(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mRead(input logic [1:0] sel);
        return mReg[sel];
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 4; k++) mReg[k] = 16'h0000;
        mFlag = 4'b0000;
    endtask

    task automatic modelStep(input logic [3:0] rs, input logic [2:0] fun, input logic [15:0] din, input logic fc);
        logic [15:0] r, nv;
        logic [31:0] s;
        logic        set, clr;
        for (int k = 0; k < 4; k++) begin
            r = mReg[k]; nv = r; set = 1'b0; clr = 1'b0;
            if (!rs[k]) begin
                case (fun)
                    3'd0: if (r == 16'h0000) begin set = 1'b1; nv = SAT ? 16'h0000 : 16'hFFFF; end
                          else nv = r - 16'd1;
                    3'd1: if (r == 16'hFFFF) begin set = 1'b1; nv = SAT ? 16'hFFFF : 16'h0000; end
                          else nv = r + 16'd1;
                    3'd2: nv = din;
                    3'd3: begin nv = 16'h0000; clr = 1'b1; end
                    3'd4: begin
                        s = {16'h0000, r} + {16'h0000, din};
                        set = (s > 32'h0000FFFF);
                        nv = (set && SAT) ? 16'hFFFF : s[15:0];
                    end
                    3'd5: begin
                        set = (din > r);
                        nv = (set && SAT) ? 16'h0000 : r - din;
                    end
                    3'd6: nv = {r[15:8], din[7:0]};
                    default: nv = r;
                endcase
            end
            mReg[k] = nv;
            if (set) mFlag[k] = 1'b1;
            else if (clr || fc) mFlag[k] = 1'b0;
        end
    endtask

    task automatic pushExpect(input string lbl);
        expQ.push_back({16'h0000, mRead(OutCSel)});  tagQ.push_back({lbl, ".OutC"});
        expQ.push_back({16'h0000, mRead(OutDSel)});  tagQ.push_back({lbl, ".OutD"});
        expQ.push_back({28'h0000000, mFlag});        tagQ.push_back({lbl, ".WrapFlags"});
    endtask

    task automatic scoreOutputs();
        logic [31:0] act [3];
        act[0] = {16'h0000, OutC};
        act[1] = {16'h0000, OutD};
        act[2] = {28'h0000000, WrapFlags};
        for (int i = 0; i < 3; i++) begin
            if (expQ.size() == 0) begin
                missCount++;
                $display("FAIL scoreboard: queue empty, got %h expected an entry", act[i]);
            end else begin
                checkResult(tagQ.pop_front(), act[i], expQ.pop_front());
            end
        end
    endtask

    task automatic stepCycle(input string lbl, input logic [3:0] rs, input logic [2:0] fun,
                             input logic [15:0] din, input logic fc, input logic [1:0] cs, input logic [1:0] ds);
        RegSel = rs; FunSel = fun; I = din; FlagClr = fc; OutCSel = cs; OutDSel = ds;
        modelStep(rs, fun, din, fc);
        pushExpect(lbl);
        @(posedge Clock);
        #1;
        scoreOutputs();
    endtask

    task automatic combCheck(input string lbl, input logic [1:0] cs, input logic [1:0] ds);
        RegSel = 4'b1111; FunSel = 3'b111; FlagClr = 1'b0; OutCSel = cs; OutDSel = ds;
        #1;
        pushExpect(lbl);
        scoreOutputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        Reset = 1'b0; I = 16'hFFFF; RegSel = 4'b0000; FunSel = 3'b010; FlagClr = 1'b0;
        OutCSel = 2'd0; OutDSel = 2'd1;
        RegSel3 = 3'b111; OutCSel3 = 2'd3; OutDSel3 = 2'd0;
        modelReset();

        // Writes attempted while reset is held must not take effect.
        repeat (3) begin
            pushExpect("inReset");
            @(posedge Clock);
            #1;
            scoreOutputs();
        end
        Reset = 1'b1;
        stepCycle("release", 4'b0000, 3'b010, 16'hFFFF, 1'b0, 2'd0, 2'd1);

        // Preload and combinational reads.
        stepCycle("loadPC",  4'b1110, 3'b010, 16'h1234, 1'b0, 2'd0, 2'd1);
        stepCycle("loadSP3", 4'b0011, 3'b010, 16'h5678, 1'b0, 2'd2, 2'd3);
        stepCycle("clrAR",   4'b1101, 3'b011, 16'h0000, 1'b0, 2'd0, 2'd1);
        combCheck("read03", 2'd0, 2'd3);
        combCheck("read21", 2'd2, 2'd1);
        stepCycle("arWrite", 4'b1101, 3'b010, 16'h3548, 1'b0, 2'd2, 2'd1);
        combCheck("read03b", 2'd0, 2'd3);

        // SP decrement from zero, sticky flag, FlagClr.
        stepCycle("spZero",  4'b1011, 3'b010, 16'h0000, 1'b0, 2'd2, 2'd0);
        stepCycle("spDec",   4'b1011, 3'b000, 16'h0000, 1'b0, 2'd2, 2'd0);
        stepCycle("hold1",   4'b1011, 3'b111, 16'h0000, 1'b0, 2'd2, 2'd0);
        stepCycle("hold2",   4'b1011, 3'b111, 16'h0000, 1'b0, 2'd2, 2'd0);
        stepCycle("flagClr", 4'b1111, 3'b111, 16'h0000, 1'b1, 2'd2, 2'd0);

        // Dual add with carry on PC only.
        stepCycle("pcFFF0",  4'b1110, 3'b010, 16'hFFF0, 1'b0, 2'd0, 2'd1);
        stepCycle("ar0010",  4'b1101, 3'b010, 16'h0010, 1'b0, 2'd0, 2'd1);
        stepCycle("dualAdd", 4'b1100, 3'b100, 16'h0020, 1'b0, 2'd0, 2'd1);
        stepCycle("stickyInc", 4'b1110, 3'b001, 16'h0000, 1'b0, 2'd0, 2'd1);

        // Low-half load and subtract with borrow.
        stepCycle("arABCD",  4'b1101, 3'b010, 16'hABCD, 1'b0, 2'd1, 2'd0);
        stepCycle("lowLoad", 4'b1101, 3'b110, 16'h1234, 1'b0, 2'd1, 2'd0);
        stepCycle("ar0001",  4'b1101, 3'b010, 16'h0001, 1'b0, 2'd1, 2'd0);
        stepCycle("subBorrow", 4'b1101, 3'b101, 16'hFFFF, 1'b0, 2'd1, 2'd0);

        // FlagClr together with a flag-setting increment: the set wins.
        stepCycle("pcFFFF",  4'b1110, 3'b010, 16'hFFFF, 1'b0, 2'd0, 2'd1);
        stepCycle("clrVsInc", 4'b1110, 3'b001, 16'h0000, 1'b1, 2'd0, 2'd1);
        stepCycle("opClr",   4'b1110, 3'b011, 16'h0000, 1'b0, 2'd0, 2'd1);
        stepCycle("pcDec0",  4'b1110, 3'b000, 16'h0000, 1'b0, 2'd0, 2'd1);
        stepCycle("clrVsOp3", 4'b1110, 3'b011, 16'h0000, 1'b1, 2'd0, 2'd1);

        // Reset asserted mid-cycle over a pending write.
        stepCycle("preRst",  4'b0000, 3'b010, 16'h7777, 1'b0, 2'd0, 2'd3);
        RegSel = 4'b0000; FunSel = 3'b001; FlagClr = 1'b0;
        #2;
        Reset = 1'b0;
        modelReset();
        #1;
        pushExpect("asyncRst");
        scoreOutputs();
        @(posedge Clock);
        #1;
        pushExpect("rstHeld");
        scoreOutputs();
        RegSel = 4'b1111;
        Reset = 1'b1;
        stepCycle("postRst", 4'b1111, 3'b010, 16'h9999, 1'b1, 2'd0, 2'd3);

        // Three-register instance: index 3 is out of range, RESET_VAL applied.
        OutCSel3 = 2'd3; OutDSel3 = 2'd0;
        #1;
        checkResult("n3.outCSel3", {16'h0000, OutC3}, 32'h00000000);
        checkResult("n3.resetVal", {16'h0000, OutD3}, 32'h000000A5);
        checkResult("n3.flags", {29'h0, WrapFlags3}, 32'h00000000);

        // Random traffic against the model.
        for (int n = 0; n < 60; n++) begin
            stepCycle("rand", 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                      16'($urandom), 1'($urandom_range(0, 3) == 0),
                      2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/address_register_file_param.md
Name: address_register_file_param

Overview:
- Parameterised successor to the fixed three-register (PC/AR/SP) address register file.
- Holds NUM_REGS address registers of WIDTH bits, written through one shared input bus under an active-low per-register select and a 3-bit function code.
- Adds offset add/subtract, partial load and sticky per-register wrap flags.
- Feeds two combinational address read ports (OutC/OutD) to memory and the ALU path of the CPU datapath.

Parameters:
- WIDTH, 16, register and data-bus width in bits; must be ≥ 4 and even.
- NUM_REGS, 4, number of address registers; index 0 = PC, 1 = AR, 2 = SP, 3+ = general.
- SEL_W, 2, width of OutCSel/OutDSel; 2**SEL_W must be ≥ NUM_REGS.
- RESET_VAL, 0, value loaded into every register on reset.

Ports:
- Clock  input  1  system clock, rising-edge active.
- Reset  input  1  asynchronous, active-low reset.
- I  input  WIDTH  shared write/offset data bus.
- RegSel  input  NUM_REGS  active-low register enable; bit k = 0 selects register k; all ones = no write.
- FunSel  input  3  operation applied to every selected register.
- FlagClr  input  1  synchronous clear of all WrapFlags.
- OutCSel  input  SEL_W  read-port C register index.
- OutDSel  input  SEL_W  read-port D register index.
- OutC  output  WIDTH  contents of register OutCSel.
- OutD  output  WIDTH  contents of register OutDSel.
- WrapFlags  output  NUM_REGS  sticky per-register wrap/borrow flag.

Behaviour:
- Reset low: all registers = RESET_VAL and WrapFlags = 0, immediately and asynchronously; held while low. Outputs follow the registers, so OutC/OutD = RESET_VAL.
- Reset release: first active Clock edge is the first functional edge.
- Read ports: purely combinational, zero latency; they reflect a register update in the same cycle as the edge.
  - Select index ≥ NUM_REGS → port drives 0.
  - C and D may select the same register.
- Write: on rising Clock, each register k with RegSel[k] = 0 executes FunSel; unselected registers hold their value and flag. Multiple selected registers each execute the same op independently, using their own old value.
- FunSel codes (R = old value, arithmetic modulo 2**WIDTH):
  - 000: R−1; sets flag if R == 0.
  - 001: R+1; sets flag if R == all-ones.
  - 010: load I.
  - 011: clear to 0; also clears this register's flag.
  - 100: R+I; sets flag on carry-out.
  - 101: R−I; sets flag on borrow (I > R).
  - 110: load low half: R[WIDTH/2−1:0] = I[WIDTH/2−1:0], upper half held.
  - 111: hold, no change.
- Flags:
  - Sticky: once set, a flag stays set until FlagClr, op 011 on that register, or reset.
  - FlagClr and a flag-setting op in the same cycle: the set wins, flag = 1 after the edge.
  - FlagClr and op 011 on the same register: flag = 0.
- RegSel all ones: no register or flag changes, except FlagClr, which still clears.
- Reset asserted mid-cycle: overrides any in-progress write; no partial update is retained.

Optional Feature:
- Macro: ADDRESS_REGISTER_FILE_SATURATE_EN.
- Defined: ops 000/001/100/101 saturate, clamping to 0 on underflow and all-ones on overflow. The flag is still set under the same conditions as in wrap mode.
- Undefined: modulo wrap as specified above. Ops 010/011/110/111 are identical in both builds.

Test Plan:
- Reset low with I = 16'hFFFF, RegSel = 0000, FunSel = 010, clocking → OutC = OutD = 0000 and WrapFlags = 0 throughout. Release, one edge → selected read = FFFF.
- Preload PC = 1234, SP = 5678, RegSel = 1111, OutCSel = 0, OutDSel = 3 → OutC = 1234, OutD = 5678 with no clock edge. OutCSel = 2 and OutDSel = 1 (AR = 0) with a write to AR of I = 3548 → OutD = 3548 after one edge; PC, SP and OutC (SP) unchanged.
- SP = 0000, RegSel = 1011, FunSel = 000 → SP = FFFF (0000 with SATURATE_EN) and WrapFlags[2] = 1. Two more edges with FunSel = 111 → flag stays 1. FlagClr = 1 for one edge → flag = 0.
- PC = FFF0, AR = 0010, RegSel = 1100, FunSel = 100, I = 0020 → PC = 0010 with flag 1; AR = 0030 with flag 0.
- AR = ABCD, FunSel = 110, I = 1234 → AR = AB34. FunSel = 101, I = FFFF on AR = 0001 → AR = 0002 with flag 1 (0000 with SATURATE_EN).
- OutCSel = 3 with NUM_REGS = 3 → OutC = 0. Same-cycle FlagClr plus PC increment from FFFF → PC = 0000, WrapFlags[0] = 1.
